// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared encodings for the backplane bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arbState_t;

    localparam logic [1:0] IDX_CPU = 2'd0;
    localparam logic [1:0] IDX_CSL = 2'd1;
    localparam logic [1:0] IDX_UBA = 2'd2;

    localparam int DEFAULT_TIMEOUT = 15;

    // Successor index in the CPU -> CSL -> UBA -> CPU rotation.
    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx >= IDX_UBA) ? IDX_CPU : idx + 2'd1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational 3-way round-robin picker
module arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [0:2] req,
    input  logic [1:0] last,
    output logic [0:2] gnt,
    output logic [1:0] gntIdx,
    output logic       valid
);

    logic [1:0] scan;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        gnt    = '0;
        gntIdx = IDX_CPU;
        valid  = 1'b0;
        scan   = nextIdx(last);
        for (int k = 0; k < 3; k++) begin
            if (!valid && req[scan]) begin
                valid     = 1'b1;
                gntIdx    = scan;
                gnt[scan] = 1'b1;
            end
            scan = nextIdx(scan);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - KS-10 backplane bus arbiter for CPU, console and UBA DMA
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpuREQI,
    input  logic        cslREQI,
    input  logic        ubaREQI,
    input  logic [0:35] cpuADDRI,
    input  logic [0:35] cslADDRI,
    input  logic [0:35] ubaADDRI,
    input  logic [0:35] cpuDATAI,
    input  logic [0:35] cslDATAI,
    input  logic [0:35] ubaDATAI,
    input  logic        busACKI,
    output logic        busREQO,
    output logic [0:35] busADDRO,
    output logic [0:35] busDATAO,
    output logic [0:2]  arbGNTO,
    output logic        cpuACKO,
    output logic        cslACKO,
    output logic        ubaACKO,
    output logic        cpuNXMO,
    output logic        cslNXMO,
    output logic        ubaNXMO,
    output logic        nxmINTR,
    output logic [0:35] nxmADDRO
);

    localparam logic [3:0] TIMER_LOAD = 4'(TIMEOUT);

    arbState_t   state, stateNext;
    logic [3:0]  timer, timerNext;
    logic [1:0]  last, lastNext;
    logic [1:0]  owner, ownerNext;

    logic [0:2]  ackQ, ackD;
    logic [0:2]  nxmQ, nxmD;
    logic        busReqD;
    logic [0:35] addrD, dataD, nxmAddrD;
    logic [0:2]  gntD;
    logic        nxmIntrD;

    logic [0:2]  pickGnt;
    logic [1:0]  pickIdx;
    logic        pickValid;
    logic [0:35] pickAddr, pickData;

    arb_rr_pick uPick (
        .req    ({cpuREQI, cslREQI, ubaREQI}),
        .last   (last),
        .gnt    (pickGnt),
        .gntIdx (pickIdx),
        .valid  (pickValid)
    );

    always_comb begin
        case (pickIdx)
            IDX_CSL: begin pickAddr = cslADDRI; pickData = cslDATAI; end
            IDX_UBA: begin pickAddr = ubaADDRI; pickData = ubaDATAI; end
            default: begin pickAddr = cpuADDRI; pickData = cpuDATAI; end
        endcase
    end

    // Output flops are updated together with the state so every port is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            last     <= IDX_UBA;
            owner    <= IDX_CPU;
            busREQO  <= 1'b0;
            busADDRO <= '0;
            busDATAO <= '0;
            arbGNTO  <= '0;
            ackQ     <= '0;
            nxmQ     <= '0;
            nxmINTR  <= 1'b0;
            nxmADDRO <= '0;
        end else begin
            state    <= stateNext;
            timer    <= timerNext;
            last     <= lastNext;
            owner    <= ownerNext;
            busREQO  <= busReqD;
            busADDRO <= addrD;
            busDATAO <= dataD;
            arbGNTO  <= gntD;
            ackQ     <= ackD;
            nxmQ     <= nxmD;
            nxmINTR  <= nxmIntrD;
            nxmADDRO <= nxmAddrD;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (pickValid) stateNext = ST_BUSY;
            ST_BUSY: if (busACKI || timer == 4'd1) stateNext = ST_DONE;
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        timerNext = timer;
        lastNext  = last;
        ownerNext = owner;
        busReqD   = busREQO;
        addrD     = busADDRO;
        dataD     = busDATAO;
        gntD      = arbGNTO;
        ackD      = '0;
        nxmD      = '0;
        nxmIntrD  = 1'b0;
        nxmAddrD  = nxmADDRO;
        case (state)
            ST_IDLE: begin
                gntD    = '0;
                busReqD = 1'b0;
                if (pickValid) begin
                    ownerNext = pickIdx;
                    gntD      = pickGnt;
                    addrD     = pickAddr;
                    dataD     = pickData;
                    timerNext = TIMER_LOAD;
                    busReqD   = 1'b1;
                end
            end
            ST_BUSY: begin
                // An ACK arriving on the expiry edge still completes the cycle normally.
                if (busACKI) begin
                    busReqD     = 1'b0;
                    ackD[owner] = 1'b1;
                    lastNext    = owner;
                end else if (timer == 4'd1) begin
                    busReqD     = 1'b0;
                    nxmD[owner] = 1'b1;
                    nxmIntrD    = 1'b1;
                    nxmAddrD    = busADDRO;
                    lastNext    = owner;
                end else begin
                    timerNext = timer - 4'd1;
                end
            end
            ST_DONE: begin
                busReqD = 1'b0;
                gntD    = '0;
            end
            default: begin
                busReqD = 1'b0;
                gntD    = '0;
            end
        endcase
    end

    assign cpuACKO = ackQ[IDX_CPU];
    assign cslACKO = ackQ[IDX_CSL];
    assign ubaACKO = ackQ[IDX_UBA];
    assign cpuNXMO = nxmQ[IDX_CPU];
    assign cslNXMO = nxmQ[IDX_CSL];
    assign ubaNXMO = nxmQ[IDX_UBA];

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuREQI, cslREQI, ubaREQI;
    logic [0:35] cpuADDRI, cslADDRI, ubaADDRI;
    logic [0:35] cpuDATAI, cslDATAI, ubaDATAI;
    logic        busACKI;
    logic        busREQO;
    logic [0:35] busADDRO, busDATAO;
    logic [0:2]  arbGNTO;
    logic        cpuACKO, cslACKO, ubaACKO;
    logic        cpuNXMO, cslNXMO, ubaNXMO;
    logic        nxmINTR;
    logic [0:35] nxmADDRO;

    int total = 0;
    int bad   = 0;

    localparam logic [35:0] A_CPU  = 36'o000000001000;
    localparam logic [35:0] D_CPU  = 36'o123456701234;
    localparam logic [35:0] A_UBA  = 36'o000017777777;
    localparam logic [35:0] A_CPU2 = 36'o000000002000;
    localparam logic [35:0] A_CSL  = 36'o000000003000;

    logic [2:0] rotation [0:3];

    bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .cpuREQI  (cpuREQI),
        .cslREQI  (cslREQI),
        .ubaREQI  (ubaREQI),
        .cpuADDRI (cpuADDRI),
        .cslADDRI (cslADDRI),
        .ubaADDRI (ubaADDRI),
        .cpuDATAI (cpuDATAI),
        .cslDATAI (cslDATAI),
        .ubaDATAI (ubaDATAI),
        .busACKI  (busACKI),
        .busREQO  (busREQO),
        .busADDRO (busADDRO),
        .busDATAO (busDATAO),
        .arbGNTO  (arbGNTO),
        .cpuACKO  (cpuACKO),
        .cslACKO  (cslACKO),
        .ubaACKO  (ubaACKO),
        .cpuNXMO  (cpuNXMO),
        .cslNXMO  (cslNXMO),
        .ubaNXMO  (ubaNXMO),
        .nxmINTR  (nxmINTR),
        .nxmADDRO (nxmADDRO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rotation[0] = 3'b100;
        rotation[1] = 3'b010;
        rotation[2] = 3'b001;
        rotation[3] = 3'b100;

        rst = 1'b1;
        cpuREQI = 1'b0; cslREQI = 1'b0; ubaREQI = 1'b0;
        cpuADDRI = A_CPU; cslADDRI = A_CSL; ubaADDRI = A_UBA;
        cpuDATAI = D_CPU; cslDATAI = 36'o222222222222; ubaDATAI = 36'o333333333333;
        busACKI = 1'b0;

        // reset state
        step();
        check("rst_busreq", 36'(busREQO), 36'd0);
        check("rst_gnt", 36'(arbGNTO), 36'd0);
        check("rst_addr", 36'(busADDRO), 36'd0);
        check("rst_nxmaddr", 36'(nxmADDRO), 36'd0);
        check("rst_acks", 36'({cpuACKO, cslACKO, ubaACKO, cpuNXMO, cslNXMO, ubaNXMO, nxmINTR}), 36'd0);
        rst = 1'b0;

        // single CPU read, ACK in the 3rd BUSY cycle
        cpuREQI = 1'b1;
        step();
        check("cpu_busreq1", 36'(busREQO), 36'd1);
        check("cpu_gnt", 36'(arbGNTO), 36'b100);
        check("cpu_addr", 36'(busADDRO), A_CPU);
        check("cpu_data", 36'(busDATAO), D_CPU);
        step();
        check("cpu_busreq2", 36'(busREQO), 36'd1);
        step();
        check("cpu_busreq3", 36'(busREQO), 36'd1);
        check("cpu_noack_yet", 36'(cpuACKO), 36'd0);
        busACKI = 1'b1;
        step();
        check("cpu_ack", 36'({cpuACKO, cslACKO, ubaACKO}), 36'b100);
        check("cpu_done_busreq", 36'(busREQO), 36'd0);
        check("cpu_done_gnt", 36'(arbGNTO), 36'b100);
        check("cpu_done_addr", 36'(busADDRO), A_CPU);
        busACKI = 1'b0;
        cpuREQI = 1'b0;
        step();
        check("cpu_ack_pulse", 36'(cpuACKO), 36'd0);
        check("cpu_idle_gnt", 36'(arbGNTO), 36'd0);

        // UBA timeout: 15 BUSY cycles then NXM
        ubaREQI = 1'b1;
        step();
        check("uba_gnt", 36'(arbGNTO), 36'b001);
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("uba_busy%0d", k), 36'(busREQO), 36'd1);
            if (k < 15) step();
        end
        check("uba_no_early_nxm", 36'(ubaNXMO), 36'd0);
        step();
        check("uba_nxm", 36'({cpuNXMO, cslNXMO, ubaNXMO}), 36'b001);
        check("uba_intr", 36'(nxmINTR), 36'd1);
        check("uba_nxmaddr", 36'(nxmADDRO), A_UBA);
        check("uba_noack", 36'(ubaACKO), 36'd0);
        check("uba_done_busreq", 36'(busREQO), 36'd0);
        ubaREQI = 1'b0;
        step();
        check("uba_nxm_pulse", 36'({ubaNXMO, nxmINTR}), 36'd0);
        check("uba_nxmaddr_hold", 36'(nxmADDRO), A_UBA);

        // ACK on the expiry edge wins over NXM
        cpuADDRI = A_CPU2;
        cpuREQI = 1'b1;
        step();
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("exp_busy%0d", k), 36'(busREQO), 36'd1);
            if (k == 15) busACKI = 1'b1;
            else step();
        end
        step();
        check("exp_ack", 36'(cpuACKO), 36'd1);
        check("exp_nonxm", 36'({cpuNXMO, nxmINTR}), 36'd0);
        check("exp_nxmaddr_keep", 36'(nxmADDRO), A_UBA);
        busACKI = 1'b0;
        cpuREQI = 1'b0;
        step();

        // CSL drops its request mid-cycle; cycle still completes
        cslREQI = 1'b1;
        step();
        check("drop_gnt", 36'(arbGNTO), 36'b010);
        check("drop_addr", 36'(busADDRO), A_CSL);
        step();
        cslREQI = 1'b0;
        check("drop_busy2", 36'(busREQO), 36'd1);
        step();
        check("drop_busy3", 36'(busREQO), 36'd1);
        step();
        check("drop_busy4", 36'(busREQO), 36'd1);
        busACKI = 1'b1;
        step();
        check("drop_ack", 36'({cpuACKO, cslACKO, ubaACKO}), 36'b010);
        busACKI = 1'b0;
        step();

        // reset in the middle of a UBA cycle
        ubaREQI = 1'b1;
        step();
        check("rstb_gnt", 36'(arbGNTO), 36'b001);
        step();
        rst = 1'b1;
        cpuREQI = 1'b1;
        cslREQI = 1'b1;
        step();
        check("rstb_busreq", 36'(busREQO), 36'd0);
        check("rstb_gnt0", 36'(arbGNTO), 36'd0);
        check("rstb_addr", 36'(busADDRO), 36'd0);
        check("rstb_nxmaddr", 36'(nxmADDRO), 36'd0);
        check("rstb_pulses", 36'({cpuACKO, cslACKO, ubaACKO, cpuNXMO, cslNXMO, ubaNXMO, nxmINTR}), 36'd0);
        rst = 1'b0;

        // three-way contention: CPU, CSL, UBA, CPU at 3 cycles each
        step();
        for (int t = 0; t < 4; t++) begin
            check($sformatf("rr_gnt%0d", t), 36'(arbGNTO), 36'(rotation[t]));
            check($sformatf("rr_busreq%0d", t), 36'(busREQO), 36'd1);
            busACKI = 1'b1;
            step();
            busACKI = 1'b0;
            check($sformatf("rr_ack%0d", t), 36'({cpuACKO, cslACKO, ubaACKO}), 36'(rotation[t]));
            check($sformatf("rr_done_busreq%0d", t), 36'(busREQO), 36'd0);
            if (t == 3) begin
                cpuREQI = 1'b0;
                cslREQI = 1'b0;
                ubaREQI = 1'b0;
            end
            step();
            check($sformatf("rr_idle_gnt%0d", t), 36'(arbGNTO), 36'd0);
            if (t < 3) step();
        end
        step();
        check("rr_quiet", 36'(busREQO), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
